// File: rtl/data_bus_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// data_bus_ctrl_pkg
// Shared constants for the data bus controller.
// Contents:
//   - memory-mapped peripheral addresses (TXDATA, STATUS, LED)
//   - STATUS register bit positions
//   - UART transmitter FSM state encoding
//   - address decode and STATUS packing helpers
// -----------------------------------------------------------------------------
package data_bus_ctrl_pkg;

   localparam logic [31:0] ADDR_TXDATA = 32'hFFFF_0000;
   localparam logic [31:0] ADDR_STATUS = 32'hFFFF_0004;
   localparam logic [31:0] ADDR_LED    = 32'hFFFF_0008;

   localparam int STAT_FULL_BIT  = 0;
   localparam int STAT_EMPTY_BIT = 1;
   localparam int STAT_BUSY_BIT  = 2;
   localparam int STAT_OVF_BIT   = 3;
   localparam int STAT_CNT_LSB   = 4;
   localparam int STAT_CNT_MSB   = 6;

   localparam logic [1:0] TX_IDLE  = 2'd0;
   localparam logic [1:0] TX_START = 2'd1;
   localparam logic [1:0] TX_DATA  = 2'd2;
   localparam logic [1:0] TX_STOP  = 2'd3;

   typedef enum logic [2:0] {
      SEL_RAM    = 3'd0,
      SEL_TXDATA = 3'd1,
      SEL_STATUS = 3'd2,
      SEL_LED    = 3'd3,
      SEL_NONE   = 3'd4
   } sel_e;

   // Lower half of the address space is RAM; the upper half holds three
   // registers and everything else is a silent hole.
   function automatic sel_e decode_addr(input logic [31:0] addr);
      sel_e sel;
      if (addr[31] == 1'b0) begin
         sel = SEL_RAM;
      end else if (addr == ADDR_TXDATA) begin
         sel = SEL_TXDATA;
      end else if (addr == ADDR_STATUS) begin
         sel = SEL_STATUS;
      end else if (addr == ADDR_LED) begin
         sel = SEL_LED;
      end else begin
         sel = SEL_NONE;
      end
      return sel;
   endfunction

   function automatic logic [31:0] pack_status(input logic [2:0] cnt,
                                               input logic       ovf,
                                               input logic       busy,
                                               input logic       empty,
                                               input logic       full);
      logic [31:0] word;
      word = 32'h0000_0000;
      word[STAT_CNT_MSB:STAT_CNT_LSB] = cnt;
      word[STAT_OVF_BIT]              = ovf;
      word[STAT_BUSY_BIT]             = busy;
      word[STAT_EMPTY_BIT]            = empty;
      word[STAT_FULL_BIT]             = full;
      return word;
   endfunction

endpackage

// File: rtl/data_bus_ctrl_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with show-ahead output (dout is the head entry whenever
// empty is low).
// Ports:
//   clk, arst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, din   : write request and data; ignored while full
//   pop         : read request; ignored while empty
//   dout        : head entry
//   full, empty : occupancy flags, based on the count before this cycle's ops
//   count       : number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok_s;
   logic             pop_ok_s;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
      logic [PTR_W-1:0] nxt;
      if (ptr == PTR_W'(DEPTH - 1)) begin
         nxt = {PTR_W{1'b0}};
      end else begin
         nxt = ptr + PTR_W'(1);
      end
      return nxt;
   endfunction

   assign full      = (count_q == CNT_W'(DEPTH));
   assign empty     = (count_q == {CNT_W{1'b0}});
   assign count     = count_q;
   assign dout      = mem_q[rd_ptr_q];
   // Full is judged before a same-cycle pop, so a push into a full FIFO is
   // dropped even when the head leaves in that cycle.
   assign push_ok_s = push & ~full;
   assign pop_ok_s  = pop & ~empty;

   // Pointer and occupancy next-state.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok_s) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         count_q  <= {CNT_W{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

endmodule

// File: rtl/data_bus_ctrl.sv
// -----------------------------------------------------------------------------
// data_bus_ctrl
// Core data-bus slave: word RAM in the lower half of the address space, plus
// a UART transmitter (byte FIFO + 8N1 serialiser) and an LED register.
// Ports:
//   clk, arst_n : clock, asynchronous active-low reset
//   addr        : byte address from the core
//   wdata, we   : store data and strobe (write at rising clk while we=1)
//   rdata       : load data, combinational from addr
//   leds        : LED register
//   uart_tx     : registered serial output, idle high
// -----------------------------------------------------------------------------
module data_bus_ctrl
   import data_bus_ctrl_pkg::*;
#(
   parameter int RAM_WORDS  = 64,
   parameter int CLK_DIV    = 434,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        arst_n,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        we,
   output logic [31:0] rdata,
   output logic [7:0]  leds,
   output logic        uart_tx
);

   localparam int RAM_AW = $clog2(RAM_WORDS);
   localparam int BAUD_W = $clog2(CLK_DIV);
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

   logic [31:0]       ram_q [RAM_WORDS];
   logic [RAM_AW-1:0] ram_idx_s;
   sel_e              sel_s;
   logic              wr_tx_s;

   logic              fifo_full_s;
   logic              fifo_empty_s;
   logic [7:0]        fifo_dout_s;
   logic [CNT_W-1:0]  fifo_count_s;
   logic              pop_s;

   logic [1:0]        state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic              tx_q, tx_d;
   logic              ovf_q, ovf_d;
   logic [7:0]        leds_q, leds_d;
   logic              baud_last_s;

   assign sel_s       = decode_addr(addr);
   assign ram_idx_s   = addr[RAM_AW+1:2];
   assign wr_tx_s     = we & (sel_s == SEL_TXDATA);
   assign baud_last_s = (baud_q == BAUD_W'(CLK_DIV - 1));
   assign leds        = leds_q;
   assign uart_tx     = tx_q;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .arst_n (arst_n),
      .push   (wr_tx_s),
      .pop    (pop_s),
      .din    (wdata[7:0]),
      .dout   (fifo_dout_s),
      .full   (fifo_full_s),
      .empty  (fifo_empty_s),
      .count  (fifo_count_s)
   );

   // RAM store port; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (we && (sel_s == SEL_RAM)) begin
         ram_q[ram_idx_s] <= wdata;
      end
   end

   // Load mux.
   always_comb begin
      rdata = 32'h0000_0000;
      case (sel_s)
         SEL_RAM:    rdata = ram_q[ram_idx_s];
         SEL_STATUS: rdata = pack_status(3'(fifo_count_s), ovf_q,
                                         (state_q != TX_IDLE),
                                         fifo_empty_s, fifo_full_s);
         SEL_LED:    rdata = {24'h00_0000, leds_q};
         default:    rdata = 32'h0000_0000;
      endcase
   end

   // Sticky overflow and LED next-state; a drop beats a same-cycle clear.
   always_comb begin
      ovf_d  = ovf_q;
      leds_d = leds_q;
      if (wr_tx_s && fifo_full_s) begin
         ovf_d = 1'b1;
      end else if (we && (sel_s == SEL_STATUS)) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
      if (we && (sel_s == SEL_LED)) begin
         leds_d = wdata[7:0];
      end else begin
         leds_d = leds_q;
      end
   end

   // Transmitter FSM: baud counter restarts on every state change.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      pop_s   = 1'b0;
      case (state_q)
         TX_IDLE: begin
            baud_d = {BAUD_W{1'b0}};
            if (!fifo_empty_s) begin
               pop_s   = 1'b1;
               shift_d = fifo_dout_s;
               bit_d   = 3'd0;
               state_d = TX_START;
            end else begin
               state_d = TX_IDLE;
            end
         end
         TX_START: begin
            if (baud_last_s) begin
               baud_d  = {BAUD_W{1'b0}};
               state_d = TX_DATA;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         TX_DATA: begin
            if (baud_last_s) begin
               baud_d  = {BAUD_W{1'b0}};
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) begin
                  bit_d   = 3'd0;
                  state_d = TX_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         TX_STOP: begin
            if (baud_last_s) begin
               baud_d  = {BAUD_W{1'b0}};
               state_d = TX_IDLE;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         default: begin
            state_d = TX_IDLE;
            baud_d  = {BAUD_W{1'b0}};
            bit_d   = 3'd0;
         end
      endcase
   end

   // Line level is derived from the next state so the registered output
   // changes on the same edge as the FSM.
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         TX_IDLE:  tx_d = 1'b1;
         TX_START: tx_d = 1'b0;
         TX_DATA:  tx_d = shift_d[0];
         TX_STOP:  tx_d = 1'b1;
         default:  tx_d = 1'b1;
      endcase
   end

   // Control registers.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q <= TX_IDLE;
         baud_q  <= {BAUD_W{1'b0}};
         bit_q   <= 3'd0;
         shift_q <= 8'h00;
         tx_q    <= 1'b1;
         ovf_q   <= 1'b0;
         leds_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         ovf_q   <= ovf_d;
         leds_q  <= leds_d;
      end
   end

endmodule

// File: doc/data_bus_ctrl.md
DATA_BUS_CTRL -- requirements
Module: data_bus_ctrl

Interface
REQ-001 The block SHALL have parameter RAM_WORDS, default 64, number of 32-bit data RAM words (power of two).
REQ-002 The block SHALL have parameter CLK_DIV, default 434, UART bit period in clk cycles (>=2).
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, UART TX FIFO entries (power of two).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 arst_n  input  1  reset, asynchronous and active-low.
REQ-006 addr  input  32  byte address from core ALU result.
REQ-007 wdata  input  32  store data from core.
REQ-008 we  input  1  store strobe from core; write occurs at rising clk while high.
REQ-009 rdata  output  32  load data to core, combinational from addr.
REQ-010 leds  output  8  LED register contents.
REQ-011 uart_tx  output  1  serial line, 8N1, LSB first, idle high.

Function
REQ-012 Decode SHALL be: addr[31]=0 -> RAM word addr[log2(RAM_WORDS)+1:2] (upper bits ignored); 0xFFFF_0000 TXDATA; 0xFFFF_0004 STATUS; 0xFFFF_0008 LED; any other addr[31]=1 address reads 0 and ignores writes.
REQ-013 RAM read SHALL be asynchronous (same-cycle rdata); RAM write SHALL update the word at the rising edge with we=1; read of a word being written returns old data until the edge.
REQ-014 TXDATA write SHALL push wdata[7:0] into the FIFO if not full; TXDATA reads return 0.
REQ-015 A TXDATA write while FIFO full (count==FIFO_DEPTH, evaluated before any same-cycle pop) SHALL drop the byte and set sticky overflow.
REQ-016 STATUS read SHALL return {zeros, count[6:4], overflow[3], busy[2], empty[1], full[0]}; busy=1 whenever FSM not IDLE.
REQ-017 Any write to STATUS SHALL clear overflow; if a drop occurs in the same cycle, set wins.
REQ-018 LED write SHALL load wdata[7:0] into leds; LED read returns {24'b0, leds}.
REQ-019 TX FSM states SHALL be IDLE, START, DATA, STOP.
REQ-020 IDLE: if FIFO non-empty, pop head into shift register, clear bit counter, go START; else stay; uart_tx=1.
REQ-021 START: uart_tx=0 for CLK_DIV cycles, then DATA.
REQ-022 DATA: drive shift[0] for CLK_DIV cycles per bit, shift right, 8 bits, then STOP.
REQ-023 STOP: uart_tx=1 for CLK_DIV cycles, then IDLE; consecutive frames therefore start 10*CLK_DIV+1 cycles apart.
REQ-024 Simultaneous push and pop with FIFO non-full SHALL both take effect; count unchanged.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.
REQ-026 Baud counter SHALL count 0..CLK_DIV-1, reset to 0 on every state change.
REQ-027 uart_tx SHALL be registered (glitch-free).

Reset
REQ-028 On arst_n low, asynchronously: FSM=IDLE, uart_tx=1, leds=0, FIFO empty (pointers, count=0), overflow=0, baud/bit counters=0.
REQ-029 Reset mid-frame SHALL abort the frame immediately with uart_tx=1; pending FIFO bytes discarded.
REQ-030 RAM contents SHALL NOT be reset (undefined after power-up).

Structure
REQ-031 Shared package SHALL hold address constants (TXDATA, STATUS, LED), STATUS bit positions and TX FSM state encoding.
REQ-032 FIFO SHALL be a sub-module sync_fifo (params WIDTH, DEPTH; ports push, pop, din, dout, full, empty, count).

Verification (CLK_DIV=4, FIFO_DEPTH=4)
REQ-033 Store 0xDEADBEEF at 0x0000_0010, then load 0x0000_0010 and 0x0000_0110 (alias, RAM_WORDS=64) -> rdata=0xDEADBEEF both.
REQ-034 Write 0x55 to TXDATA -> uart_tx low 4 cycles, then 1,0,1,0,1,0,1,0 each 4 cycles, high 4 cycles; STATUS busy=1 during, 0x02 after.
REQ-035 Write 0x01..0x06 to TXDATA on 6 consecutive cycles, FSM idle -> bytes 0x01..0x05 transmitted in order, 0x06 dropped, STATUS bit3=1; write STATUS -> bit3=0.
REQ-036 Write 0xA5 to LED -> leds=0xA5 next edge, LED read=0x0000_00A5; read 0xFFFF_0010 -> 0.
REQ-037 Assert arst_n=0 during DATA bit 3 with 2 bytes queued -> uart_tx=1 immediately, STATUS=0x02 after release, no further frames.
REQ-038 FIFO full, TXDATA write coinciding with FSM pop -> byte dropped, overflow=1, count=3 next cycle.
